// File: rtl/branch_resolve_predict_pkg.sv
// Shared encodings for EX branch resolution and the branch history table.
// Optional BRANCH_STATS_EN adds resolution/mispredict counters to the top.
package branch_resolve_predict_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   function automatic logic [1:0] ctr_step(
      input logic [1:0] c,
      input logic       taken
   );
      logic [1:0] r;
      r = c;
      if (taken) begin
         if (c != ST) r = c + 2'd1;
      end else begin
         if (c != SNT) r = c - 2'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/branch_resolve_predict_bht.sv
// Direct-mapped table of 2-bit saturating counters.
// One combinational read port (IF), one read-modify-write port (EX).
module branch_bht
   import branch_resolve_predict_pkg::*;
#(
   parameter int         BHT_DEPTH = 64,
   parameter logic [1:0] CTR_INIT  = 2'b01,
   localparam int        IDX_W     = $clog2(BHT_DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_ctr,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   logic [1:0] ctr_q [BHT_DEPTH];

   // Read sees the registered table only: no same-cycle bypass.
   assign rd_ctr = ctr_q[rd_idx];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            ctr_q[i] <= CTR_INIT;
         end
      end else if (upd_en) begin
         ctr_q[upd_idx] <= ctr_step(ctr_q[upd_idx], upd_taken);
      end
   end

endmodule

// File: rtl/branch_resolve_predict.sv
// EX branch resolution, BHT prediction for IF, redirect and flush sequencing.
// Define BRANCH_STATS_EN to add stat_branches / stat_mispredicts outputs.
module branch_resolve_predict
   import branch_resolve_predict_pkg::*;
#(
   parameter int         PC_WIDTH     = 32,
   parameter int         BHT_DEPTH    = 64,
   parameter int         FLUSH_CYCLES = 2,
   parameter logic [1:0] CTR_INIT     = 2'b01
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PC_WIDTH-1:0] if_pc,
   output logic                if_predict_taken,
   input  logic                ex_branch,
   input  logic [2:0]          ex_funct3,
   input  logic                ex_zero,
   input  logic                ex_greater_than,
   input  logic                ex_greater_than_u,
   input  logic [PC_WIDTH-1:0] ex_pc,
   input  logic [PC_WIDTH-1:0] ex_target,
   input  logic                ex_predicted_taken,
   output logic                switch_branch,
   output logic                mispredict,
   output logic                flush,
   output logic                redirect_valid,
   output logic [PC_WIDTH-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]         stat_branches,
   output logic [31:0]         stat_mispredicts
`endif
);

   localparam int IDX_W = $clog2(BHT_DEPTH);
   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic       is_br, taken, resolve;
   logic [1:0] rd_ctr;
   logic       unused_pc_bits;

   assign unused_pc_bits = ^if_pc;

   always_comb begin
      is_br = 1'b1;
      taken = 1'b0;
      unique case (1'b1)
         (ex_funct3 == F3_BEQ):  taken = ex_zero;
         (ex_funct3 == F3_BNE):  taken = !ex_zero;
         (ex_funct3 == F3_BLT):  taken = !ex_greater_than;
         (ex_funct3 == F3_BGE):  taken = ex_greater_than;
         (ex_funct3 == F3_BLTU): taken = !ex_greater_than_u;
         (ex_funct3 == F3_BGEU): taken = ex_greater_than_u;
         default:                is_br = 1'b0;
      endcase
   end

   // Wrong-path branches arriving during FLUSH never resolve.
   assign resolve       = ex_branch && is_br && (state_q == RUN);
   assign switch_branch = resolve && taken;
   assign mispredict    = resolve && (taken != ex_predicted_taken);

   branch_bht #(
      .BHT_DEPTH (BHT_DEPTH),
      .CTR_INIT  (CTR_INIT)
   ) u_bht (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (if_pc[IDX_W+1:2]),
      .rd_ctr    (rd_ctr),
      .upd_en    (resolve),
      .upd_idx   (ex_pc[IDX_W+1:2]),
      .upd_taken (taken)
   );

   assign if_predict_taken = rd_ctr[1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (mispredict) begin
               state_d = FLUSH;
               cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            end
         end
         FLUSH: begin
            if (cnt_q == '0) state_d = RUN;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= RUN;
         cnt_q          <= '0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         flush          <= (state_d == FLUSH);
         redirect_valid <= mispredict;
         if (mispredict) begin
            redirect_pc <= taken ? ex_target : ex_pc + PC_WIDTH'(4);
         end
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (resolve)    stat_branches    <= stat_branches + 32'd1;
         if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Randomised + directed bench against a behavioural branch/BHT model.
// Stat checks are active when BRANCH_STATS_EN is defined.
module tb_branch_resolve_predict;

   localparam int PW    = 32;
   localparam int DEPTH = 64;
   localparam int FC    = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [PW-1:0] if_pc;
   logic          if_predict_taken;
   logic          ex_branch;
   logic [2:0]    ex_funct3;
   logic          ex_zero;
   logic          ex_greater_than;
   logic          ex_greater_than_u;
   logic [PW-1:0] ex_pc;
   logic [PW-1:0] ex_target;
   logic          ex_predicted_taken;
   logic          switch_branch;
   logic          mispredict;
   logic          flush;
   logic          redirect_valid;
   logic [PW-1:0] redirect_pc;
`ifdef BRANCH_STATS_EN
   logic [31:0]   stat_branches;
   logic [31:0]   stat_mispredicts;
`endif

   always #5 clk = ~clk;

   branch_resolve_predict #(
      .PC_WIDTH     (PW),
      .BHT_DEPTH    (DEPTH),
      .FLUSH_CYCLES (FC),
      .CTR_INIT     (2'b01)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .if_pc              (if_pc),
      .if_predict_taken   (if_predict_taken),
      .ex_branch          (ex_branch),
      .ex_funct3          (ex_funct3),
      .ex_zero            (ex_zero),
      .ex_greater_than    (ex_greater_than),
      .ex_greater_than_u  (ex_greater_than_u),
      .ex_pc              (ex_pc),
      .ex_target          (ex_target),
      .ex_predicted_taken (ex_predicted_taken),
      .switch_branch      (switch_branch),
      .mispredict         (mispredict),
      .flush              (flush),
      .redirect_valid     (redirect_valid),
      .redirect_pc        (redirect_pc)
`ifdef BRANCH_STATS_EN
      ,
      .stat_branches      (stat_branches),
      .stat_mispredicts   (stat_mispredicts)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model: counter values 0..3, flush cycles still to come, redirect regs.
   int            m_bht [DEPTH];
   int            m_flush_rem;
   bit            m_rv;
   logic [PW-1:0] m_rpc;
   logic [31:0]   m_sb, m_sm;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int idx(input logic [PW-1:0] pc);
      return int'((pc >> 2) % DEPTH);
   endfunction

   function automatic bit br_taken(input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit is_cond(input logic [2:0] f3);
      return !(f3 == 3'd2 || f3 == 3'd3);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
      m_flush_rem = 0;
      m_rv  = 1'b0;
      m_rpc = '0;
      m_sb  = '0;
      m_sm  = '0;
   endtask

   // One cycle: drive on negedge, check just after, update model at posedge.
   task automatic step(input bit rst, input bit br, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [PW-1:0] pc, input logic [PW-1:0] tgt,
                       input bit pred, input logic [PW-1:0] ipc);
      bit v, tk, mp;
      @(negedge clk);
      rst_n              = !rst;
      ex_branch          = br;
      ex_funct3          = f3;
      ex_zero            = (a == b);
      ex_greater_than    = ($signed(a) >= $signed(b));
      ex_greater_than_u  = (a >= b);
      ex_pc              = pc;
      ex_target          = tgt;
      ex_predicted_taken = pred;
      if_pc              = ipc;
      #1;
      tk = br_taken(f3, a, b);
      v  = br && is_cond(f3) && (m_flush_rem == 0);
      mp = v && (tk != pred);
      check("if_predict_taken", 32'(if_predict_taken), 32'(m_bht[idx(ipc)] >= 2));
      check("switch_branch", 32'(switch_branch), 32'(v && tk));
      check("mispredict", 32'(mispredict), 32'(mp));
      check("flush", 32'(flush), 32'(m_flush_rem > 0));
      check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
      check("redirect_pc", redirect_pc, m_rpc);
`ifdef BRANCH_STATS_EN
      check("stat_branches", stat_branches, m_sb);
      check("stat_mispredicts", stat_mispredicts, m_sm);
`endif
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (v) begin
            if (tk) m_bht[idx(pc)] = (m_bht[idx(pc)] == 3) ? 3 : m_bht[idx(pc)] + 1;
            else    m_bht[idx(pc)] = (m_bht[idx(pc)] == 0) ? 0 : m_bht[idx(pc)] - 1;
            m_sb++;
         end
         if (m_flush_rem > 0) m_flush_rem--;
         m_rv = mp;
         if (mp) begin
            m_flush_rem = FC;
            m_rpc = tk ? tgt : pc + 32'd4;
            m_sm++;
         end
      end
   endtask

   task automatic idle(input logic [PW-1:0] ipc);
      step(0, 0, 3'd0, 0, 0, 0, 0, 0, ipc);
   endtask

   initial begin
      logic [PW-1:0] p, q;
      logic [31:0]   a, b;
      rst_n = 1'b0;
      ex_branch = 1'b0; ex_funct3 = '0; ex_zero = 1'b0;
      ex_greater_than = 1'b0; ex_greater_than_u = 1'b0;
      ex_pc = '0; ex_target = '0; ex_predicted_taken = 1'b0; if_pc = '0;
      model_reset();
      @(posedge clk);
      step(1, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0);
      idle(32'h00); idle(32'h04); idle(32'hFC);

      // beq taken, predicted not-taken: redirect to target, 2-cycle flush
      step(0, 1, 3'd0, 7, 7, 32'h100, 32'h140, 0, 32'h100);
      idle(32'h100); idle(32'h100); idle(32'h100);

      // bltu not taken, predicted taken; bne during flush ignored
      step(0, 1, 3'd6, 9, 3, 32'h200, 32'h280, 1, 32'h200);
      step(0, 1, 3'd1, 1, 2, 32'h200, 32'h2C0, 0, 32'h200);
      idle(32'h200); idle(32'h200);

      // Four taken bge at 0x300, lookup of same index in the same cycle
      step(0, 1, 3'd5, 5, 5, 32'h300, 32'h380, 0, 32'h300);
      idle(32'h300); idle(32'h300);
      repeat (3) step(0, 1, 3'd5, 8, 2, 32'h300, 32'h380, 1, 32'h300);
      idle(32'h300);

      // Non-branch funct3 never resolves
      step(0, 1, 3'd2, 4, 4, 32'h300, 32'h380, 0, 32'h300);
      step(0, 1, 3'd3, 4, 5, 32'h300, 32'h380, 1, 32'h300);

      // Reset during the first flush cycle
      step(0, 1, 3'd1, 1, 2, 32'h400, 32'h440, 0, 32'h300);
      step(1, 0, 3'd0, 0, 0, 0, 0, 0, 32'h300);
      idle(32'h300); idle(32'h100);

      // Wrap of pc+4
      step(0, 1, 3'd7, 1, 2, 32'hFFFF_FFFC, 32'h10, 1, 32'h0);
      idle(32'h0); idle(32'h0);

      for (int n = 0; n < 3000; n++) begin
         p = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
         if ($urandom_range(0, 50) == 0) p = 32'hFFFF_FFFC;
         q = ($urandom_range(0, 3) == 0) ? p : (32'($urandom_range(0, 15)) << 2);
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
              3'($urandom_range(0, 7)), a, b, p, $urandom,
              $urandom_range(0, 1) == 1, q);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
